// File: rtl/dplca_txop_table_pkg.sv
// Shared encodings and constants for the DPLCA TXOP claim table.
package dplca_txop_table_pkg;

    localparam int unsigned TXOP_ID_W              = 8;
    localparam int unsigned CLAIM_W                = 1 << TXOP_ID_W;
    localparam int unsigned AGE_W                  = 8;
    localparam int unsigned DPLCA_AGING_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        BEACON = 2'b00,
        COMMIT = 2'b01,
        NONE   = 2'b10
    } rx_cmd_e;

    localparam logic ON   = 1'b1;
    localparam logic OFF  = 1'b0;
    localparam logic OK   = 1'b1;
    localparam logic FAIL = 1'b0;

    // Node count is max id + 1, held at the top of the 8-bit range.
    function automatic logic [TXOP_ID_W-1:0] sat_inc(input logic [TXOP_ID_W-1:0] v);
        return (v == {TXOP_ID_W{1'b1}}) ? v : TXOP_ID_W'(v + 1'b1);
    endfunction

endpackage

// File: rtl/dplca_beacon_detect.sv
// Tracks the previous rx command and strobes the first clock of each beacon.
module dplca_beacon_detect
    import dplca_txop_table_pkg::*;
(
    input  logic       clk,
    input  logic       plca_reset_n,
    input  logic [1:0] rx_cmd,
    output logic       beacon_edge_c
);

    logic [1:0] rx_cmd_q;
    logic [1:0] rx_cmd_d;

    always_comb begin
        rx_cmd_d = rx_cmd;
    end

    // History resets to BEACON so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (!plca_reset_n) begin
            rx_cmd_q <= BEACON;
        end else begin
            rx_cmd_q <= rx_cmd_d;
        end
    end

    assign beacon_edge_c = (rx_cmd == BEACON) && (rx_cmd_q != BEACON);

endmodule

// File: rtl/dplca_txop_table.sv
// Per-TXOP claim accumulation across beacon cycles with windowed aging,
// publishing the claim table and node count at each beacon boundary.
module dplca_txop_table
    import dplca_txop_table_pkg::*;
#(
    parameter int unsigned DPLCA_AGING_CYCLES = DPLCA_AGING_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               plca_reset_n,
    input  logic               dplca_aging,
    input  logic [1:0]         rx_cmd,
    input  logic               txop_valid,
    input  logic [7:0]         txop_id,
    input  logic               txop_claimed,
    output logic [CLAIM_W-1:0] txop_claim_table,
    output logic [7:0]         dplca_txop_id,
    output logic [7:0]         dplca_txop_node_count,
    output logic               dplca_txop_table_upd,
    output logic               dplca_new_age
);

    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(DPLCA_AGING_CYCLES - 1);

    logic                 beacon_edge_c;

    logic [CLAIM_W-1:0]   table_q,   table_d;
    logic [CLAIM_W-1:0]   cur_q,     cur_d;
    logic [CLAIM_W-1:0]   win_q,     win_d;
    logic [AGE_W-1:0]     age_q,     age_d;
    logic [TXOP_ID_W-1:0] max_q,     max_d;
    logic [TXOP_ID_W-1:0] id_q,      id_d;
    logic [TXOP_ID_W-1:0] cnt_q,     cnt_d;
    logic                 upd_q,     upd_d;
    logic                 new_age_q, new_age_d;

    logic [CLAIM_W-1:0]   cur_n;
    logic [TXOP_ID_W-1:0] max_n;

    dplca_beacon_detect u_beacon_detect (
        .clk           (clk),
        .plca_reset_n  (plca_reset_n),
        .rx_cmd        (rx_cmd),
        .beacon_edge_c (beacon_edge_c)
    );

    // Capture, boundary publish and aging; a TXOP on the edge clock belongs to the ending cycle.
    always_comb begin
        table_d   = table_q;
        cur_d     = cur_q;
        win_d     = win_q;
        age_d     = age_q;
        max_d     = max_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        upd_d     = 1'b0;
        new_age_d = 1'b0;
        cur_n     = cur_q;
        max_n     = max_q;

        if (dplca_aging == OFF) begin
            table_d = '0;
            cur_d   = '0;
            win_d   = '0;
            age_d   = '0;
            max_d   = '0;
            id_d    = '0;
        end else begin
            if (txop_valid) begin
                id_d = txop_id;
                if (txop_claimed) begin
                    cur_n[txop_id] = 1'b1;
                end
                if (txop_id > max_n) begin
                    max_n = txop_id;
                end
            end
            cur_d = cur_n;
            max_d = max_n;

            if (beacon_edge_c) begin
                if (age_q == AGE_LAST) begin
                    table_d   = win_q | cur_n;
                    win_d     = '0;
                    age_d     = '0;
                    new_age_d = 1'b1;
                end else begin
                    table_d = table_q | cur_n;
                    win_d   = win_q | cur_n;
                    age_d   = AGE_W'(age_q + 1'b1);
                end
                upd_d = 1'b1;
                cnt_d = sat_inc(max_n);
                cur_d = '0;
                max_d = '0;
                id_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!plca_reset_n) begin
            table_q   <= '0;
            cur_q     <= '0;
            win_q     <= '0;
            age_q     <= '0;
            max_q     <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            upd_q     <= 1'b0;
            new_age_q <= 1'b0;
        end else begin
            table_q   <= table_d;
            cur_q     <= cur_d;
            win_q     <= win_d;
            age_q     <= age_d;
            max_q     <= max_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            upd_q     <= upd_d;
            new_age_q <= new_age_d;
        end
    end

    assign txop_claim_table      = table_q;
    assign dplca_txop_id         = id_q;
    assign dplca_txop_node_count = cnt_q;
    assign dplca_txop_table_upd  = upd_q;
    assign dplca_new_age         = new_age_q;

endmodule

// File: tb/tb_dplca_txop_table.sv
// Bench for dplca_txop_table: three instances (aging 8, 2, 1) share one stimulus stream.
module tb_dplca_txop_table;
    import dplca_txop_table_pkg::*;

    localparam int NI = 3;
    localparam int unsigned AG [NI] = '{8, 2, 1};

    typedef struct {
        logic [255:0] tbl;
        logic [7:0]   cnt;
        logic         age;
    } exp_t;

    logic       clk = 1'b0;
    logic       plca_reset_n;
    logic       dplca_aging;
    logic [1:0] rx_cmd;
    logic       txop_valid;
    logic [7:0] txop_id;
    logic       txop_claimed;

    logic [255:0] tbl_w [NI];
    logic [7:0]   id_w  [NI];
    logic [7:0]   cnt_w [NI];
    logic         upd_w [NI];
    logic         age_w [NI];

    exp_t         exp_q [NI][$];
    logic [255:0] m_cur [NI];
    logic [255:0] m_win [NI];
    logic [255:0] m_tbl [NI];
    int unsigned  m_age [NI];
    logic [7:0]   m_max [NI];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  upd_cnt [NI];
    int  nage_cnt[NI];
    logic upd_prev[NI];
    exp_t mon_e;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dplca_txop_table #(.DPLCA_AGING_CYCLES(AG[g])) u_dut (
            .clk                   (clk),
            .plca_reset_n          (plca_reset_n),
            .dplca_aging           (dplca_aging),
            .rx_cmd                (rx_cmd),
            .txop_valid            (txop_valid),
            .txop_id               (txop_id),
            .txop_claimed          (txop_claimed),
            .txop_claim_table      (tbl_w[g]),
            .dplca_txop_id         (id_w[g]),
            .dplca_txop_node_count (cnt_w[g]),
            .dplca_txop_table_upd  (upd_w[g]),
            .dplca_new_age         (age_w[g])
        );
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] bset(input int a, input int b = -1, input int c = -1);
        logic [255:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    // Scoreboard pop on every published table.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (upd_w[i] === 1'b1) begin
                upd_cnt[i]++;
                chk($sformatf("u%0d_upd_back_to_back", i), 256'(upd_prev[i]), 256'(0));
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("u%0d_upd_unexpected", i), 256'(1), 256'(0));
                end else begin
                    mon_e = exp_q[i].pop_front();
                    chk($sformatf("u%0d_table", i), tbl_w[i], mon_e.tbl);
                    chk($sformatf("u%0d_node_count", i), 256'(cnt_w[i]), 256'(mon_e.cnt));
                    chk($sformatf("u%0d_new_age", i), 256'(age_w[i]), 256'(mon_e.age));
                end
            end else if (age_w[i] === 1'b1) begin
                chk($sformatf("u%0d_new_age_without_upd", i), 256'(1), 256'(0));
            end
            if (age_w[i] === 1'b1) nage_cnt[i]++;
            upd_prev[i] = (upd_w[i] === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_clear();
        for (int i = 0; i < NI; i++) begin
            m_cur[i] = '0; m_win[i] = '0; m_tbl[i] = '0; m_age[i] = 0; m_max[i] = '0;
        end
    endtask

    task automatic m_txop(input int id, input bit claimed);
        if (dplca_aging) begin
            for (int i = 0; i < NI; i++) begin
                if (claimed) m_cur[i][id] = 1'b1;
                if (8'(id) > m_max[i]) m_max[i] = 8'(id);
            end
        end
    endtask

    task automatic txop(input int id, input bit claimed);
        rx_cmd       = claimed ? COMMIT : NONE;
        txop_valid   = 1'b1;
        txop_id      = 8'(id);
        txop_claimed = claimed;
        m_txop(id, claimed);
        tick();
        txop_valid   = 1'b0;
        txop_claimed = 1'b0;
        rx_cmd       = NONE;
        for (int i = 0; i < NI; i++) chk($sformatf("u%0d_txop_id", i), 256'(id_w[i]), 256'(id));
    endtask

    // Beacon held for 'hold' clocks; optional TXOP (sid >= 0) closes on the edge clock.
    task automatic beacon(input int hold, input int sid = -1, input bit sclaim = 1'b0);
        exp_t e;
        logic [255:0] c;
        rx_cmd = NONE;
        tick();
        rx_cmd = BEACON;
        if (sid >= 0) begin
            txop_valid = 1'b1; txop_id = 8'(sid); txop_claimed = sclaim;
            m_txop(sid, sclaim);
        end
        for (int i = 0; i < NI; i++) begin
            c = m_cur[i];
            if (m_age[i] == AG[i] - 1) begin
                m_tbl[i] = m_win[i] | c; m_win[i] = '0; m_age[i] = 0; e.age = 1'b1;
            end else begin
                m_tbl[i] = m_tbl[i] | c; m_win[i] = m_win[i] | c; m_age[i]++; e.age = 1'b0;
            end
            e.tbl = m_tbl[i];
            e.cnt = (m_max[i] == 8'hFF) ? 8'hFF : 8'(m_max[i] + 8'd1);
            exp_q[i].push_back(e);
            m_cur[i] = '0; m_max[i] = '0;
        end
        tick();
        txop_valid = 1'b0; txop_claimed = 1'b0;
        repeat (hold - 1) tick();
        rx_cmd = NONE;
        tick();
        for (int i = 0; i < NI; i++) chk($sformatf("u%0d_id_after_beacon", i), 256'(id_w[i]), 256'(0));
    endtask

    task automatic aging_set(input bit on);
        dplca_aging = on;
        if (!on) m_clear();
        tick();
        if (!on) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d_table_aging_off", i), tbl_w[i], 256'(0));
                chk($sformatf("u%0d_upd_aging_off", i), 256'(upd_w[i]), 256'(0));
            end
        end
    endtask

    task automatic do_reset(input int clks);
        plca_reset_n = 1'b0;
        m_clear();
        repeat (clks) tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d_rst_table", i), tbl_w[i], 256'(0));
            chk($sformatf("u%0d_rst_id", i), 256'(id_w[i]), 256'(0));
            chk($sformatf("u%0d_rst_cnt", i), 256'(cnt_w[i]), 256'(0));
            chk($sformatf("u%0d_rst_upd", i), 256'(upd_w[i]), 256'(0));
            chk($sformatf("u%0d_rst_age", i), 256'(age_w[i]), 256'(0));
        end
        plca_reset_n = 1'b1;
    endtask

    initial begin
        int u0;
        int a0;
        for (int i = 0; i < NI; i++) begin
            upd_cnt[i] = 0; nage_cnt[i] = 0; upd_prev[i] = 1'b0;
        end
        dplca_aging  = 1'b1;
        rx_cmd       = NONE;
        txop_valid   = 1'b0;
        txop_id      = 8'd0;
        txop_claimed = 1'b0;
        do_reset(2);

        // Three cycles of claims {0,3,5}.
        for (int k = 0; k < 3; k++) begin
            txop(0, 1'b1); txop(3, 1'b1); txop(5, 1'b1);
            beacon(1);
        end
        chk("p1_table", tbl_w[0], bset(0, 3, 5));
        chk("p1_node_count", 256'(cnt_w[0]), 256'(6));
        chk("p1_upd_count", 256'(upd_cnt[0]), 256'(3));
        chk("p1_no_new_age", 256'(nage_cnt[0]), 256'(0));

        // Two-cycle aging window drops id 4.
        aging_set(1'b0); aging_set(1'b1);
        a0 = nage_cnt[1];
        txop(0, 1'b1); txop(4, 1'b1); txop(4, 1'b1); beacon(1);
        txop(0, 1'b1); beacon(1);
        chk("p2_table_win1", tbl_w[1], bset(0, 4));
        txop(0, 1'b1); beacon(1);
        txop(0, 1'b1); beacon(1);
        chk("p2_table_win2", tbl_w[1], bset(0));
        chk("p2_new_age_count", 256'(nage_cnt[1] - a0), 256'(2));

        // TXOP on the beacon edge clock belongs to the ending cycle.
        txop(1, 1'b1);
        beacon(1, 7, 1'b1);
        chk("p3_table_exact", tbl_w[2], bset(1, 7));
        chk("p3_bit7", 256'(tbl_w[0][7]), 256'(1));

        // Long beacon publishes once; empty cycle counts one node.
        u0 = upd_cnt[0];
        beacon(5);
        chk("p4_one_upd", 256'(upd_cnt[0] - u0), 256'(1));
        chk("p4_empty_node_count", 256'(cnt_w[0]), 256'(1));

        // Aging drop mid-window, then a fresh eight-beacon window.
        aging_set(1'b0); aging_set(1'b1);
        txop(0, 1'b1); txop(2, 1'b1); beacon(1);
        chk("p5_table", tbl_w[0], bset(0, 2));
        txop(3, 1'b1);
        u0 = upd_cnt[0];
        aging_set(1'b0);
        aging_set(1'b1);
        chk("p5_no_pulse", 256'(upd_cnt[0] - u0), 256'(0));
        a0 = nage_cnt[0];
        for (int k = 1; k <= 8; k++) begin
            txop(1, 1'b1);
            beacon(1);
            if (k == 7) chk("p5_no_age_before_8", 256'(nage_cnt[0] - a0), 256'(0));
        end
        chk("p5_age_on_8", 256'(nage_cnt[0] - a0), 256'(1));

        // Node count saturates at 255.
        txop(255, 1'b1);
        beacon(1);
        chk("p6_sat_count", 256'(cnt_w[0]), 256'(255));

        // Reset mid-cycle discards pending claims.
        txop(1, 1'b1); txop(2, 1'b1);
        do_reset(1);
        txop(6, 1'b1);
        beacon(1);
        chk("p7_table", tbl_w[0], bset(6));
        chk("p7_node_count", 256'(cnt_w[0]), 256'(7));

        tick(); tick();
        for (int i = 0; i < NI; i++) chk($sformatf("u%0d_pending", i), 256'(exp_q[i].size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
